// File: rtl/branch_target_buffer_if.sv
// ----------------------------------------------------------------------------
// branch_target_buffer_if
// Groups the IF-stage lookup and ID-stage update signals of the branch target
// buffer into one bundle.
//   master : pipeline side. Drives lookup_pc, upd_*, flush_all and
//            receives pred_*.
//   slave  : predictor side (branch_target_buffer).
// Signals:
//   lookup_pc   [XLEN]     IF-stage PC
//   pred_hit    [1]        valid entry with matching tag
//   pred_taken  [1]        predicted taken
//   pred_target [XLEN]     next-PC prediction
//   pred_ghr    [GHR_BITS] history snapshot used for this lookup
//   upd_en      [1]        resolved-branch update strobe
//   upd_pc      [XLEN]     PC of the resolved branch
//   upd_taken   [1]        actual outcome
//   upd_target  [XLEN]     actual branch target
//   upd_ghr     [GHR_BITS] pred_ghr captured with that branch
//   flush_all   [1]        invalidate the whole table
// ----------------------------------------------------------------------------
interface branch_target_buffer_if #(
    parameter int XLEN     = 32,
    parameter int GHR_BITS = 6
);
    logic [XLEN-1:0]     lookup_pc;
    logic                pred_hit;
    logic                pred_taken;
    logic [XLEN-1:0]     pred_target;
    logic [GHR_BITS-1:0] pred_ghr;
    logic                upd_en;
    logic [XLEN-1:0]     upd_pc;
    logic                upd_taken;
    logic [XLEN-1:0]     upd_target;
    logic [GHR_BITS-1:0] upd_ghr;
    logic                flush_all;

    modport master (
        output lookup_pc, upd_en, upd_pc, upd_taken, upd_target, upd_ghr, flush_all,
        input  pred_hit, pred_taken, pred_target, pred_ghr
    );

    modport slave (
        input  lookup_pc, upd_en, upd_pc, upd_taken, upd_target, upd_ghr, flush_all,
        output pred_hit, pred_taken, pred_target, pred_ghr
    );
endinterface

// File: rtl/branch_target_buffer.sv
// ----------------------------------------------------------------------------
// branch_target_buffer
// Direct-mapped branch target buffer with a per-entry saturating-counter
// direction predictor. Lookup is combinational (IF stage); resolved branches
// update the table on the rising clock edge (ID stage).
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    branch_target_buffer_if.slave (lookup, prediction, update, flush)
//
// Optional feature macro: BTB_GSHARE_EN
//   Defined   : a global history register is XORed into the counter index
//               (gshare). Tag/valid/target remain indexed by the plain PC.
//   Undefined : plain PC indexing, pred_ghr tied to zero, upd_ghr ignored,
//               no history register exists.
// ----------------------------------------------------------------------------
module branch_target_buffer #(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 64,
    parameter int TAG_BITS = 8,
    parameter int CTR_BITS = 2,
    parameter int GHR_BITS = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    branch_target_buffer_if.slave  bus
);
    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam int TAG_LSB  = IDX_BITS + 2;
    localparam int TAG_MSB  = TAG_BITS + IDX_BITS + 1;

    localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));

    typedef logic [IDX_BITS-1:0] idx_t;

    logic                valid_q  [ENTRIES];
    logic                valid_d  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [TAG_BITS-1:0] tag_d    [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];
    logic [XLEN-1:0]     target_d [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
    logic [CTR_BITS-1:0] ctr_d    [ENTRIES];

    idx_t                lk_idx, lk_cidx, up_idx, up_cidx;
    logic [TAG_BITS-1:0] lk_tag, up_tag;
    logic                lk_hit, up_hit;

    assign lk_idx = bus.lookup_pc[IDX_BITS+1:2];
    assign lk_tag = bus.lookup_pc[TAG_MSB:TAG_LSB];
    assign up_idx = bus.upd_pc[IDX_BITS+1:2];
    assign up_tag = bus.upd_pc[TAG_MSB:TAG_LSB];

`ifdef BTB_GSHARE_EN
    logic [GHR_BITS-1:0] ghr_q, ghr_d;
    logic                unused_upd_pc;

    always_comb begin
        ghr_d = ghr_q;
        if (bus.flush_all) begin
            ghr_d = '0;
        end else if (bus.upd_en) begin
            // Shift in the outcome; the cast drops the oldest history bit.
            ghr_d = GHR_BITS'({ghr_q, bus.upd_taken});
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    // History is zero-extended into the index before folding.
    assign lk_cidx       = lk_idx ^ idx_t'(ghr_q);
    assign up_cidx       = up_idx ^ idx_t'(bus.upd_ghr);
    assign bus.pred_ghr  = ghr_q;
    assign unused_upd_pc = ^bus.upd_pc;
`else
    logic unused_inputs;

    assign lk_cidx       = lk_idx;
    assign up_cidx       = up_idx;
    assign bus.pred_ghr  = '0;
    assign unused_inputs = ^{bus.upd_pc, bus.upd_ghr};
`endif

    // Lookup path: reads current (pre-update) state, no bypass from upd_*.
    assign lk_hit          = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign bus.pred_hit    = lk_hit;
    assign bus.pred_taken  = lk_hit && ctr_q[lk_cidx][CTR_BITS-1];
    assign bus.pred_target = bus.pred_taken ? target_q[lk_idx]
                                            : bus.lookup_pc + XLEN'(4);

    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (bus.flush_all) begin
            // Flush wins over a simultaneous update; counters keep their history.
            for (int i = 0; i < ENTRIES; i++) begin
                valid_d[i] = 1'b0;
            end
        end else if (bus.upd_en) begin
            if (up_hit) begin
                if (bus.upd_taken) begin
                    target_d[up_idx] = bus.upd_target;
                    if (ctr_q[up_cidx] != CTR_MAX) begin
                        ctr_d[up_cidx] = ctr_q[up_cidx] + CTR_BITS'(1);
                    end
                end else if (ctr_q[up_cidx] != '0) begin
                    ctr_d[up_cidx] = ctr_q[up_cidx] - CTR_BITS'(1);
                end
            end else if (bus.upd_taken) begin
                // Allocate on a taken miss; silently replaces any alias.
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = bus.upd_target;
                ctr_d[up_cidx]   = CTR_WT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end
endmodule

// File: tb/tb_branch_target_buffer.sv
// ----------------------------------------------------------------------------
// tb_branch_target_buffer
// Directed stimulus against a table-level model of the predictor. A compare
// process checks every output on every falling clock edge; literal checks at
// key points pin the model to hand-computed values.
// ----------------------------------------------------------------------------
module tb_branch_target_buffer;
`ifdef BTB_GSHARE_EN
    localparam bit GS = 1'b1;
`else
    localparam bit GS = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    bit   check_en;

    branch_target_buffer_if #(.XLEN(32), .GHR_BITS(6)) bif ();

    branch_target_buffer #(
        .XLEN(32), .ENTRIES(64), .TAG_BITS(8), .CTR_BITS(2), .GHR_BITS(6)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    bit          m_valid [64];
    int          m_tag   [64];
    logic [31:0] m_tgt   [64];
    int          m_ctr   [64];
    int          m_ghr;

    function automatic int pc_idx(logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic int pc_tag(logic [31:0] pc);
        return int'((pc / 256) % 256);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) begin
                m_valid[i] = 1'b0;
                m_ctr[i]   = 1;
            end
            m_ghr = 0;
        end else if (bif.flush_all) begin
            for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
            m_ghr = 0;
        end else if (bif.upd_en) begin
            int  i, c;
            bit  h;
            i = pc_idx(bif.upd_pc);
            c = GS ? (i ^ int'(bif.upd_ghr)) : i;
            h = m_valid[i] && (m_tag[i] == pc_tag(bif.upd_pc));
            if (h) begin
                if (bif.upd_taken) begin
                    m_tgt[i] = bif.upd_target;
                    m_ctr[c] = (m_ctr[c] >= 3) ? 3 : m_ctr[c] + 1;
                end else begin
                    m_ctr[c] = (m_ctr[c] <= 0) ? 0 : m_ctr[c] - 1;
                end
            end else if (bif.upd_taken) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = pc_tag(bif.upd_pc);
                m_tgt[i]   = bif.upd_target;
                m_ctr[c]   = 2;
            end
            if (GS) m_ghr = ((m_ghr * 2) + int'(bif.upd_taken)) % 64;
        end
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (check_en) begin
            int          i, c;
            bit          h, t;
            logic [31:0] tg;
            i  = pc_idx(bif.lookup_pc);
            c  = GS ? (i ^ m_ghr) : i;
            h  = m_valid[i] && (m_tag[i] == pc_tag(bif.lookup_pc));
            t  = h && (m_ctr[c] >= 2);
            tg = t ? m_tgt[i] : bif.lookup_pc + 32'd4;
            chk("cyc_hit",    32'(bif.pred_hit),   32'(h));
            chk("cyc_taken",  32'(bif.pred_taken), 32'(t));
            chk("cyc_target", bif.pred_target,     tg);
            chk("cyc_ghr",    32'(bif.pred_ghr),   GS ? 32'(m_ghr) : 32'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(logic [31:0] pc, logic tk, logic [31:0] tgt);
        bif.upd_en     = 1'b1;
        bif.upd_pc     = pc;
        bif.upd_taken  = tk;
        bif.upd_target = tgt;
        bif.upd_ghr    = GS ? 6'(m_ghr) : 6'h2A;
        step();
        bif.upd_en = 1'b0;
        $display("upd pc=%h taken=%0b target=%h", pc, tk, tgt);
    endtask

    task automatic look(logic [31:0] pc, string name, logic eh, logic et, logic [31:0] etg);
        bif.lookup_pc = pc;
        #1;
        $display("lookup %s pc=%h hit=%0b taken=%0b target=%h", name, pc,
                 bif.pred_hit, bif.pred_taken, bif.pred_target);
        chk({name, "_hit"},    32'(bif.pred_hit),   32'(eh));
        chk({name, "_taken"},  32'(bif.pred_taken), 32'(et));
        chk({name, "_target"}, bif.pred_target,     etg);
    endtask

    initial begin
        total = 0;
        bad = 0;
        check_en = 1'b0;
        rst_n = 1'b1;
        bif.lookup_pc  = 32'h100;
        bif.upd_en     = 1'b0;
        bif.upd_pc     = '0;
        bif.upd_taken  = 1'b0;
        bif.upd_target = '0;
        bif.upd_ghr    = '0;
        bif.flush_all  = 1'b0;
        #2 rst_n = 1'b0;
        check_en = 1'b1;
        step();
        step();
        rst_n = 1'b1;

`ifndef BTB_GSHARE_EN
        // 1: reset state
        look(32'h100, "rst", 1'b0, 1'b0, 32'h104);
        look(32'hFFFF_FFFC, "wrap", 1'b0, 1'b0, 32'h0);
        // 2: allocate
        upd(32'h100, 1'b1, 32'h80);
        look(32'h100, "alloc", 1'b1, 1'b1, 32'h80);
        // 3: saturation
        upd(32'h100, 1'b0, 32'h0);
        look(32'h100, "nt1", 1'b1, 1'b0, 32'h104);
        upd(32'h100, 1'b0, 32'h0);
        upd(32'h100, 1'b0, 32'h0);
        look(32'h100, "nt3", 1'b1, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 32'h80);
        look(32'h100, "t1", 1'b1, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 32'h80);
        look(32'h100, "t2", 1'b1, 1'b1, 32'h80);
        upd(32'h100, 1'b1, 32'h80);
        upd(32'h100, 1'b1, 32'h80);
        upd(32'h100, 1'b0, 32'h0);
        look(32'h100, "sat_hi", 1'b1, 1'b1, 32'h80);
        // other index, unrelated entry
        upd(32'h1234, 1'b1, 32'h5678);
        look(32'h1234, "idx_d", 1'b1, 1'b1, 32'h5678);
        // 4: aliasing
        look(32'h200, "alias_miss", 1'b0, 1'b0, 32'h204);
        upd(32'h200, 1'b0, 32'h0);
        look(32'h100, "alias_nt", 1'b1, 1'b1, 32'h80);
        upd(32'h200, 1'b1, 32'h40);
        look(32'h200, "alias_new", 1'b1, 1'b1, 32'h40);
        look(32'h100, "alias_old", 1'b0, 1'b0, 32'h104);
        // 5: same-cycle lookup/update, then flush with update
        upd(32'h100, 1'b1, 32'h80);
        bif.upd_en = 1'b1; bif.upd_pc = 32'h100; bif.upd_taken = 1'b0;
        look(32'h100, "same_pre", 1'b1, 1'b1, 32'h80);
        step();
        bif.upd_en = 1'b0;
        look(32'h100, "same_post", 1'b1, 1'b0, 32'h104);
        bif.flush_all = 1'b1;
        upd(32'h100, 1'b1, 32'h90);
        bif.flush_all = 1'b0;
        look(32'h100, "flush_a", 1'b0, 1'b0, 32'h104);
        look(32'h1234, "flush_b", 1'b0, 1'b0, 32'h1238);
        // 6: asynchronous reset mid-cycle
        upd(32'h100, 1'b1, 32'h80);
        look(32'h100, "pre_rst", 1'b1, 1'b1, 32'h80);
        rst_n = 1'b0;
        #1;
        chk("async_hit", 32'(bif.pred_hit), 32'd0);
        chk("async_target", bif.pred_target, 32'h104);
        $display("async reset hit=%0b", bif.pred_hit);
        step();
        rst_n = 1'b1;
        step();
        look(32'h100, "post_rst", 1'b0, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 32'h80);
        look(32'h100, "realloc", 1'b1, 1'b1, 32'h80);
`else
        // 7: gshare history folding
        upd(32'h100, 1'b1, 32'h80);
        upd(32'h100, 1'b1, 32'h80);
        upd(32'h100, 1'b0, 32'h0);
        look(32'h100, "gs", 1'b1, 1'b0, 32'h104);
        chk("gs_ghr", 32'(bif.pred_ghr), 32'h06);
        bif.flush_all = 1'b1;
        step();
        bif.flush_all = 1'b0;
        look(32'h100, "gs_flush", 1'b0, 1'b0, 32'h104);
        chk("gs_ghr0", 32'(bif.pred_ghr), 32'h00);
`endif
        step();
        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Parametrised successor to the single-counter branch predictor in the 5-stage RISC-V pipeline.
- Per-entry branch target buffer plus saturating-counter history table, indexed by PC.
- Combinational lookup in IF supplies direction and target. Branch resolution in ID writes updates back on the clock edge.
- Optional gshare indexing folds global branch history into the index.

Parameters:
XLEN, 32, PC/target width
ENTRIES, 64, table depth; power of 2, >=4; IDX_BITS = log2(ENTRIES)
TAG_BITS, 8, tag width; tag = pc[TAG_BITS+IDX_BITS+1 : IDX_BITS+2]
CTR_BITS, 2, saturating counter width, >=1
GHR_BITS, 6, global history length (GSHARE only); must be <= IDX_BITS

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
lookup_pc  in  XLEN  IF-stage PC
pred_hit  out  1  valid entry with matching tag
pred_taken  out  1  predicted taken
pred_target  out  XLEN  next-PC prediction
pred_ghr  out  GHR_BITS  history snapshot used for this lookup
upd_en  in  1  resolved branch update strobe (ID stage)
upd_pc  in  XLEN  PC of resolved branch
upd_taken  in  1  actual outcome
upd_target  in  XLEN  actual branch target
upd_ghr  in  GHR_BITS  pred_ghr captured with that branch
flush_all  in  1  invalidate whole table

Behaviour:
- Index = pc[IDX_BITS+1:2].
- Entry fields: valid, tag, target, ctr.
- Reset (reset=0, async): all valid=0; all ctr = 2^(CTR_BITS-1)-1 (weakly not-taken, 01 for CTR_BITS=2); GHR=0.
- Reset mid-operation clears state immediately. Outputs settle to the miss response within the same cycle.
- Lookup is combinational, zero latency:
  - pred_hit = valid && tag match.
  - pred_taken = pred_hit && ctr MSB.
  - pred_target = entry target when pred_taken, else lookup_pc+4 (mod 2^XLEN).
- Update is synchronous on the rising edge when upd_en=1.
- Update on hit (valid && tag match):
  - ctr saturating +1 if taken, -1 if not taken.
  - Saturates at 2^CTR_BITS-1 and at 0; no wrap.
  - target <= upd_target if taken.
- Update on miss:
  - taken: allocate. valid=1, tag, target=upd_target, ctr=2^(CTR_BITS-1) (weakly taken). Direct-mapped; overwrites any alias.
  - not taken: no change.
- Lookup and update to the same entry in the same cycle: lookup returns pre-update contents. No bypass.
- flush_all=1: all valid <= 0 and GHR <= 0 next edge. Counters are untouched. Flush dominates a same-cycle upd_en.
- No handshake or back-pressure. A stalled IF simply re-presents lookup_pc. The update path never stalls.

Optional Feature:
- Macro: BTB_GSHARE_EN.
- Defined:
  - GHR register. Lookup counter index = pc index XOR {0,GHR}; pred_ghr = GHR.
  - Update counter index = upd_pc index XOR {0,upd_ghr}.
  - On upd_en: GHR <= {GHR[GHR_BITS-2:0], upd_taken}.
  - Tag, valid and target stay indexed by the plain PC index. Counter array is separate.
- Undefined:
  - Plain PC indexing; pred_ghr tied 0; upd_ghr ignored.
  - No GHR flop is synthesised.

Test Plan:
All scenarios use defaults with the macro undefined: idx = pc[7:2], tag = pc[15:8].
1. Reset release, lookup_pc=0x00000100 -> pred_hit=0, pred_taken=0, pred_target=0x00000104.
2. upd_en, upd_pc=0x100, taken, target=0x80; next cycle lookup 0x100 -> hit=1, taken=1 (ctr=10), target=0x80.
3. Counter saturation on 0x100:
   - Three not-taken updates -> ctr 01, 00, 00; lookup gives hit=1, taken=0, target=0x104.
   - Then four taken updates -> ctr 01, 10, 11, 11; taken=1.
4. Aliasing: 0x200 (same idx 0, tag 0x02) misses after training 0x100.
   - Not-taken update to 0x200 -> 0x100 still hits.
   - Taken update to 0x200 with target=0x40 -> 0x200 hits with target 0x40; 0x100 misses.
5. Same cycle, lookup 0x100 while a not-taken update to 0x100 with ctr=10 -> lookup shows taken=1; next cycle taken=0. Then flush_all together with a taken upd_en -> all lookups miss the next cycle.
6. Async reset pulsed mid-cycle after training -> pred_hit falls without a clock edge; entries stay invalid after release.
7. With BTB_GSHARE_EN defined: updates T,T,N -> GHR=000110. Lookup 0x100 -> pred_ghr=0x06; counter read from index 0^6=6.
